// File: rtl/mem_port_arbiter_if.sv
// Bus bundle shared by the two requesters, the arbiter and the single memory port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MSG_BITS      = 3
);
  logic [2*MSG_BITS-1:0]      req_msg;
  logic [2*ADDRESS_WIDTH-1:0] req_address;
  logic [2*DATA_WIDTH-1:0]    req_data;
  logic [2*MSG_BITS-1:0]      resp_msg;
  logic [2*ADDRESS_WIDTH-1:0] resp_address;
  logic [2*DATA_WIDTH-1:0]    resp_data;
  logic [MSG_BITS-1:0]        mem_msg_out;
  logic [ADDRESS_WIDTH-1:0]   mem_address_out;
  logic [DATA_WIDTH-1:0]      mem_data_out;
  logic [MSG_BITS-1:0]        mem_msg_in;
  logic [ADDRESS_WIDTH-1:0]   mem_address_in;
  logic [DATA_WIDTH-1:0]      mem_data_in;

  modport slave (
    input  req_msg, req_address, req_data,
    input  mem_msg_in, mem_address_in, mem_data_in,
    output resp_msg, resp_address, resp_data,
    output mem_msg_out, mem_address_out, mem_data_out
  );

  modport master (
    output req_msg, req_address, req_data,
    output mem_msg_in, mem_address_in, mem_data_in,
    input  resp_msg, resp_address, resp_data,
    input  mem_msg_out, mem_address_out, mem_data_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters, one transaction in flight.
// Define MEM_ARB_TIMEOUT_EN to add a watchdog that aborts unanswered transactions with MSG_ERR.
module mem_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int MSG_BITS       = 3,
  parameter int MSG_NO_REQ     = 0,
  parameter int MSG_READ       = 1,
  parameter int MSG_WRITE      = 2,
  parameter int MSG_RESP       = 3,
  parameter int MSG_ACK        = 4,
  parameter int MSG_ERR        = 7,
  parameter int TIMEOUT_BITS   = 8,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [MSG_BITS-1:0] NO_REQ_CODE = MSG_BITS'(MSG_NO_REQ);
  localparam logic [MSG_BITS-1:0] READ_CODE   = MSG_BITS'(MSG_READ);
  localparam logic [MSG_BITS-1:0] WRITE_CODE  = MSG_BITS'(MSG_WRITE);
  localparam logic [MSG_BITS-1:0] RESP_CODE   = MSG_BITS'(MSG_RESP);
  localparam logic [MSG_BITS-1:0] ACK_CODE    = MSG_BITS'(MSG_ACK);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << TIMEOUT_BITS) - 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES does not fit in TIMEOUT_BITS");
  end
  if (MSG_ERR >= (1 << MSG_BITS)) begin : g_bad_err_code
    $error("MSG_ERR does not fit in MSG_BITS");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                   state;
  logic                     ptr;    // requester favoured on the next conflict
  logic                     owner;  // requester that holds the current grant
  logic [MSG_BITS-1:0]      mem_msg_q;
  logic [ADDRESS_WIDTH-1:0] mem_address_q;
  logic [DATA_WIDTH-1:0]    mem_data_q;
  logic [MSG_BITS-1:0]      resp_msg_q     [2];
  logic [ADDRESS_WIDTH-1:0] resp_address_q [2];
  logic [DATA_WIDTH-1:0]    resp_data_q    [2];

  logic [MSG_BITS-1:0]      req_msg_a      [2];
  logic [ADDRESS_WIDTH-1:0] req_address_a  [2];
  logic [DATA_WIDTH-1:0]    req_data_a     [2];
  logic [1:0]               requesting;
  logic                     winner;
  logic                     mem_done;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_BITS-1:0] WD_LAST  = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [MSG_BITS-1:0]     ERR_CODE = MSG_BITS'(MSG_ERR);
  logic [TIMEOUT_BITS-1:0] wd_count;
  logic                    timeout_q;
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign req_msg_a[0]     = bus.req_msg[MSG_BITS-1:0];
  assign req_msg_a[1]     = bus.req_msg[2*MSG_BITS-1:MSG_BITS];
  assign req_address_a[0] = bus.req_address[ADDRESS_WIDTH-1:0];
  assign req_address_a[1] = bus.req_address[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH];
  assign req_data_a[0]    = bus.req_data[DATA_WIDTH-1:0];
  assign req_data_a[1]    = bus.req_data[2*DATA_WIDTH-1:DATA_WIDTH];

  always_comb begin
    // NOTE: every variable gets a value on every pass, so no latch can be inferred.
    requesting = '0;
    for (int i = 0; i < 2; i++) begin
      requesting[i] = (req_msg_a[i] == READ_CODE) || (req_msg_a[i] == WRITE_CODE);
    end
    winner   = (&requesting) ? ptr : requesting[1];
    mem_done = (bus.mem_msg_in == RESP_CODE) || (bus.mem_msg_in == ACK_CODE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      owner         <= 1'b0;
      grant         <= 2'b00;
      busy          <= 1'b0;
      mem_msg_q     <= NO_REQ_CODE;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      // NOTE: the response slots drive outputs directly, so this small array is reset too.
      for (int i = 0; i < 2; i++) begin
        resp_msg_q[i]     <= NO_REQ_CODE;
        resp_address_q[i] <= '0;
        resp_data_q[i]    <= '0;
      end
`ifdef MEM_ARB_TIMEOUT_EN
      wd_count  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      unique case (state)
        IDLE: begin
          if (|requesting) begin
            mem_msg_q     <= req_msg_a[winner];
            mem_address_q <= req_address_a[winner];
            mem_data_q    <= req_data_a[winner];
            owner         <= winner;
            grant         <= winner ? 2'b10 : 2'b01;
            busy          <= 1'b1;
            ptr           <= ~winner;
`ifdef MEM_ARB_TIMEOUT_EN
            wd_count      <= '0;
`endif
            state         <= BUSY;
          end
        end

        BUSY: begin
          if (mem_done) begin
            resp_msg_q[owner]     <= bus.mem_msg_in;
            resp_address_q[owner] <= bus.mem_address_in;
            resp_data_q[owner]    <= bus.mem_data_in;
            mem_msg_q             <= NO_REQ_CODE;
            mem_address_q         <= '0;
            mem_data_q            <= '0;
            state                 <= RESP;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (wd_count == WD_LAST) begin
            // Abort: the requester sees MSG_ERR at the address it asked for.
            resp_msg_q[owner]     <= ERR_CODE;
            resp_address_q[owner] <= mem_address_q;
            resp_data_q[owner]    <= '0;
            mem_msg_q             <= NO_REQ_CODE;
            mem_address_q         <= '0;
            mem_data_q            <= '0;
            timeout_q             <= 1'b1;
            state                 <= RESP;
          end else begin
            wd_count <= wd_count + 1'b1;
          end
`endif
        end

        RESP: begin
          for (int i = 0; i < 2; i++) begin
            resp_msg_q[i]     <= NO_REQ_CODE;
            resp_address_q[i] <= '0;
            resp_data_q[i]    <= '0;
          end
          grant <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_msg_out     = mem_msg_q;
  assign bus.mem_address_out = mem_address_q;
  assign bus.mem_data_out    = mem_data_q;
  assign bus.resp_msg        = {resp_msg_q[1], resp_msg_q[0]};
  assign bus.resp_address    = {resp_address_q[1], resp_address_q[0]};
  assign bus.resp_data       = {resp_data_q[1], resp_data_q[0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model, directed scenarios, random traffic.
// Watchdog scenarios are included when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;
  localparam int MB = 3;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 200;
`endif
  localparam logic [MB-1:0] C_NO = 3'd0;
  localparam logic [MB-1:0] C_RD = 3'd1;
  localparam logic [MB-1:0] C_WR = 3'd2;
  localparam logic [MB-1:0] C_RS = 3'd3;
  localparam logic [MB-1:0] C_AK = 3'd4;
  localparam logic [MB-1:0] C_ER = 3'd7;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] grant;
  logic       busy;
  logic       timeout_err;

  mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MSG_BITS(MB)) bus ();

  mem_port_arbiter #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MSG_BITS(MB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_req(input logic [MB-1:0] m);
    return (m == C_RD) || (m == C_WR);
  endfunction

  function automatic logic [MB-1:0] req_of(input int i);
    return bus.req_msg[i*MB +: MB];
  endfunction

  task automatic set_req(input int i, input logic [MB-1:0] m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_msg[i*MB +: MB]     = m;
    bus.req_address[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW]    = d;
  endtask

  task automatic set_mem(input logic [MB-1:0] m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.mem_msg_in     = m;
    bus.mem_address_in = a;
    bus.mem_data_in    = d;
  endtask

  // Transaction-level reference: one open transaction record plus the fairness pointer.
  int              cur = -1;     // owner of the open transaction, -1 when none
  bit              answered = 0; // response (or abort) delivered, now in its single response cycle
  int              age = 0;      // clock edges spent waiting on memory
  int              ptr_m = 0;
  int              txn_id = 0;
  logic [MB-1:0]   t_msg = '0;
  logic [AW-1:0]   t_addr = '0;
  logic [DW-1:0]   t_data = '0;
  logic [MB-1:0]   e_rmsg [2] = '{default: '0};
  logic [AW-1:0]   e_raddr[2] = '{default: '0};
  logic [DW-1:0]   e_rdata[2] = '{default: '0};
  bit              e_terr = 0;

  function automatic logic [MB-1:0] exp_mem_msg();
    return (cur >= 0 && !answered) ? t_msg : C_NO;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur = -1; answered = 0; ptr_m = 0; e_terr = 0;
      e_rmsg = '{default: '0}; e_raddr = '{default: '0}; e_rdata = '{default: '0};
    end else if (cur >= 0 && answered) begin
      cur = -1; answered = 0;
      e_rmsg = '{default: '0}; e_raddr = '{default: '0}; e_rdata = '{default: '0};
    end else if (cur < 0) begin
      if (is_req(req_of(0)) || is_req(req_of(1))) begin
        if (is_req(req_of(0)) && is_req(req_of(1))) cur = ptr_m;
        else cur = is_req(req_of(0)) ? 0 : 1;
        ptr_m  = 1 - cur;
        t_msg  = req_of(cur);
        t_addr = bus.req_address[cur*AW +: AW];
        t_data = bus.req_data[cur*DW +: DW];
        age    = 0;
        txn_id++;
      end
    end else begin
      age++;
      if (bus.mem_msg_in == C_RS || bus.mem_msg_in == C_AK) begin
        e_rmsg[cur] = bus.mem_msg_in; e_raddr[cur] = bus.mem_address_in; e_rdata[cur] = bus.mem_data_in;
        answered = 1;
      end
`ifdef MEM_ARB_TIMEOUT_EN
      else if (age == TO) begin
        e_rmsg[cur] = C_ER; e_raddr[cur] = t_addr; e_rdata[cur] = '0;
        e_terr = 1; answered = 1;
      end
`endif
    end
  end

  // Every-cycle comparison of all outputs against the reference.
  always @(negedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("resp_msg%0d", i), bus.resp_msg[i*MB +: MB], e_rmsg[i]);
        check($sformatf("resp_address%0d", i), bus.resp_address[i*AW +: AW], e_raddr[i]);
        check($sformatf("resp_data%0d", i), bus.resp_data[i*DW +: DW], e_rdata[i]);
      end
      check("mem_msg_out", bus.mem_msg_out, exp_mem_msg());
      if (exp_mem_msg() != C_NO) begin
        check("mem_address_out", bus.mem_address_out, t_addr);
        check("mem_data_out", bus.mem_data_out, t_data);
      end
      check("grant", grant, (cur >= 0) ? (2'b01 << cur) : 2'b00);
      check("busy", busy, cur >= 0);
      check("timeout_err", timeout_err, e_terr);
    end
  end

  logic [MB-1:0] junk_req [6] = '{3'd0, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [MB-1:0] junk_mem [5] = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd6};
  int served = 0;
  int mem_wait = 0;

  initial begin
    set_req(0, C_NO, '0, '0);
    set_req(1, C_NO, '0, '0);
    set_mem(C_NO, '0, '0);
    repeat (2) @(negedge clock);
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_msg", bus.mem_msg_out, C_NO);
    check("rst_resp_msg", bus.resp_msg, '0);
    reset = 1'b1;
    @(negedge clock);

    // Requester 0 reads 0x40, memory answers five cycles later.
    set_req(0, C_RD, 32'h40, '0);
    @(negedge clock);
    check("rd_mem_msg", bus.mem_msg_out, C_RD);
    check("rd_mem_addr", bus.mem_address_out, 32'h40);
    check("rd_grant", grant, 2'b01);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("rd_grant_hold", grant, 2'b01);
      check("rd_mem_hold", bus.mem_msg_out, C_RD);
    end
    set_mem(C_RS, 32'h40, 32'hDEADBEEF);
    @(negedge clock);
    check("rd_resp0_msg", bus.resp_msg[2:0], C_RS);
    check("rd_resp0_addr", bus.resp_address[31:0], 32'h40);
    check("rd_resp0_data", bus.resp_data[31:0], 32'hDEADBEEF);
    check("rd_resp1_msg", bus.resp_msg[5:3], C_NO);
    check("rd_grant_resp", grant, 2'b01);
    set_req(0, C_NO, '0, '0);
    set_mem(C_NO, '0, '0);
    @(negedge clock);
    check("rd_after_resp", bus.resp_msg, '0);
    check("rd_after_grant", grant, 2'b00);

    // Requester 1 writes; memory port holds the write until the ack.
    set_req(1, C_WR, 32'h10, 32'h12345678);
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      check("wr_mem_msg", bus.mem_msg_out, C_WR);
      check("wr_mem_addr", bus.mem_address_out, 32'h10);
      check("wr_mem_data", bus.mem_data_out, 32'h12345678);
      @(negedge clock);
    end
    set_mem(C_AK, 32'h10, '0);
    @(negedge clock);
    check("wr_resp1_msg", bus.resp_msg[5:3], C_AK);
    check("wr_resp0_msg", bus.resp_msg[2:0], C_NO);
    check("wr_grant", grant, 2'b10);
    set_req(1, C_NO, '0, '0);
    set_mem(C_NO, '0, '0);
    @(negedge clock);

    // Stray memory responses while idle are ignored.
    set_mem(C_RS, 32'h99, 32'hCAFE);
    @(negedge clock);
    check("spur_resp", bus.resp_msg, '0);
    check("spur_busy", busy, 1'b0);
    set_mem(C_AK, 32'h98, 32'hBEEF);
    @(negedge clock);
    check("spur_resp2", bus.resp_msg, '0);
    check("spur_grant", grant, 2'b00);
    set_mem(C_NO, '0, '0);

    // Reset mid-transaction clears everything without a clock edge.
    set_req(0, C_RD, 32'h300, '0);
    @(negedge clock);
    check("rstmid_grant_before", grant, 2'b01);
    #2 reset = 1'b0;
    #1;
    check("rstmid_grant", grant, 2'b00);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_mem_msg", bus.mem_msg_out, C_NO);
    check("rstmid_mem_addr", bus.mem_address_out, '0);
    check("rstmid_resp", bus.resp_msg, '0);
    set_req(0, C_NO, '0, '0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rstmid_no_resp", bus.resp_msg, '0);

    // Simultaneous requests after reset alternate 0,1,0,1 with one idle gap.
    set_req(0, C_RD, 32'h100, '0);
    set_req(1, C_RD, 32'h200, '0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clock);
      check($sformatf("rr_grant%0d", n), grant, (n % 2 == 0) ? 2'b01 : 2'b10);
      set_mem(C_RS, (n % 2 == 0) ? 32'h100 : 32'h200, 32'(n));
      @(negedge clock);
      check($sformatf("rr_resp%0d", n), bus.resp_msg[(n%2)*MB +: MB], C_RS);
      set_req(n % 2, C_NO, '0, '0);
      set_mem(C_NO, '0, '0);
      @(negedge clock);
      check($sformatf("rr_gap%0d", n), busy, 1'b0);
      if (n < 3) set_req(n % 2, C_RD, (n % 2 == 0) ? 32'h100 : 32'h200, '0);
    end
    set_req(0, C_NO, '0, '0);
    set_req(1, C_NO, '0, '0);
    @(negedge clock);

`ifdef MEM_ARB_TIMEOUT_EN
    // Silent memory: abort with MSG_ERR after TO busy cycles, then normal service resumes.
    set_req(0, C_RD, 32'h80, '0);
    @(negedge clock);
    for (int k = 0; k < TO - 1; k++) begin
      @(negedge clock);
      check("to_wait_resp", bus.resp_msg, '0);
    end
    @(negedge clock);
    check("to_err_msg", bus.resp_msg[2:0], C_ER);
    check("to_err_addr", bus.resp_address[31:0], 32'h80);
    check("to_err_data", bus.resp_data[31:0], '0);
    check("to_flag", timeout_err, 1'b1);
    check("to_mem_drop", bus.mem_msg_out, C_NO);
    set_req(0, C_NO, '0, '0);
    @(negedge clock);
    set_req(1, C_WR, 32'h44, 32'h55);
    @(negedge clock);
    set_mem(C_AK, 32'h44, '0);
    @(negedge clock);
    check("to_next_resp", bus.resp_msg[5:3], C_AK);
    check("to_flag_sticky", timeout_err, 1'b1);
    set_req(1, C_NO, '0, '0);
    set_mem(C_NO, '0, '0);
    @(negedge clock);
`endif

    // Random traffic: requesters hold until answered, memory answers after 0..4 busy cycles.
    served = txn_id;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        if (cur == i && answered) set_req(i, C_NO, '0, '0);
        else if (!is_req(req_of(i))) begin
          if ($urandom_range(0, 3) == 0) set_req(i, MB'($urandom_range(1, 2)), $urandom, $urandom);
          else set_req(i, junk_req[$urandom_range(0, 5)], $urandom, $urandom);
        end
      end
      if (cur >= 0 && !answered) begin
        if (txn_id != served) begin
          served = txn_id;
          mem_wait = $urandom_range(0, 4);
        end
        if (mem_wait == 0) set_mem((t_msg == C_RD) ? C_RS : C_AK, t_addr, $urandom);
        else begin
          mem_wait--;
          set_mem(junk_mem[$urandom_range(0, 4)], $urandom, $urandom);
        end
      end else begin
        set_mem(($urandom_range(0, 3) == 0) ? C_RS : C_NO, $urandom, $urandom);
      end
    end

    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
